ram_arbiter: RTL

Shares the CPU's single RAM port between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read/write). It sits between the `cpu` core and the RAM macro in the `clka` domain. It arbitrates round-robin, drives the RAM control, address and data lines from registers, waits out the RAM read latency, and returns data with a one-cycle acknowledge to the winning requester.

---
 rtl/ram_arbiter.sv | 81 ++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one RAM port between instruction fetch and load/store
module ram_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clka,
   input  logic                  rst,
   input  logic                  f_req,
   input  logic [ADDR_WIDTH-1:0] f_addr,
   output logic                  f_ack,
   output logic [DATA_WIDTH-1:0] f_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, next;
   logic [1:0] cnt;
   logic owner, last_grant, any, pick_d;
   // state register
   always_ff @(posedge clka)
      state <= rst ? IDLE : next;
   // arbitration and next state; on a tie the side not served last wins
   always_comb begin
      any = f_req | d_req;
      pick_d = d_req & (~f_req | ~last_grant);
      next = state;
      case (state)
         IDLE:    next = any ? ISSUE : IDLE;
         ISSUE:   next = ram_we ? RESP : WAIT;
         WAIT:    next = (cnt == 2'd0) ? RESP : WAIT;
         default: next = IDLE;
      endcase
   end
   // registered RAM controls, latency counter, read data capture and acks
   always_ff @(posedge clka) begin
      if (rst) begin
         owner <= 1'b0;
         last_grant <= 1'b1;
         cnt <= 2'd0;
         ram_en <= 1'b0;
         ram_we <= 1'b0;
         ram_addr <= '0;
         ram_din <= '0;
         f_rdata <= '0;
         d_rdata <= '0;
         f_ack <= 1'b0;
         d_ack <= 1'b0;
      end else begin
         if (state == IDLE && any) begin
            owner <= pick_d;
            last_grant <= pick_d;
            ram_en <= 1'b1;
            ram_we <= pick_d & d_we;
            ram_addr <= pick_d ? d_addr : f_addr;
            if (pick_d) ram_din <= d_wdata;
         end
         if (state == ISSUE) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            cnt <= 2'(RD_LATENCY - 1);
         end
         if (state == WAIT) begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd0 && owner) d_rdata <= ram_dout;
            if (cnt == 2'd0 && !owner) f_rdata <= ram_dout;
         end
         f_ack <= (next == RESP) & ~owner;
         d_ack <= (next == RESP) & owner;
      end
   end
endmodule
